// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: load/store -> req/ack transaction, stalls until done.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EX_MEM_READ,
   input  logic        EX_MEM_WRITE,
   input  logic [2:0]  EX_FUNC3,
   input  logic [31:0] EX_ADDR,
   input  logic [31:0] EX_STORE_DATA,
   output logic        MEM_STALL,
   output logic        DMEM_REQ,
   output logic        DMEM_WE,
   output logic [31:0] DMEM_ADDR,
   output logic [31:0] DMEM_WDATA,
   output logic [3:0]  DMEM_BE,
   input  logic [31:0] DMEM_RDATA,
   input  logic        DMEM_ACK,
   output logic [31:0] MEM_DATA_OUT,
   output logic        MEM_FAULT,
   output logic        MEM_MISALIGN
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       off_q;
   size_t            size_q;
   logic             load_q;

   logic             access;
   logic [1:0]       off;
   size_t            size;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic             misalign;
   logic             timeout;
   logic [31:0]      load_data;

   // Undefined FUNC3 encodings (011, 110, 111) fall into the word case.
   always_comb begin
      access = EX_MEM_READ | EX_MEM_WRITE;
      off    = EX_ADDR[1:0];
      size   = SZ_W;
      be     = 4'b1111;
      wdata  = EX_STORE_DATA;
      unique case (EX_FUNC3[1:0])
         2'b00: begin
            size  = SZ_B;
            be    = 4'b0001 << off;
            wdata = {4{EX_STORE_DATA[7:0]}};
         end
         2'b01: begin
            size  = SZ_H;
            be    = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{EX_STORE_DATA[15:0]}};
         end
         default: begin
            size  = SZ_W;
            be    = 4'b1111;
            wdata = EX_STORE_DATA;
         end
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign timeout = (MAX_WAIT != 0) && (wait_cnt == CNT_W'(MAX_WAIT - 1));

   always_comb begin
      load_data = DMEM_RDATA;
      unique case (size_q)
         SZ_B:    load_data = {24'b0, DMEM_RDATA[{off_q, 3'b000} +: 8]};
         SZ_H:    load_data = off_q[1] ? {16'b0, DMEM_RDATA[31:16]} : {16'b0, DMEM_RDATA[15:0]};
         default: load_data = DMEM_RDATA;
      endcase
   end

   assign MEM_STALL = (state == REQ) || ((state == IDLE) && access);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         off_q        <= '0;
         size_q       <= SZ_B;
         load_q       <= 1'b0;
         DMEM_REQ     <= 1'b0;
         DMEM_WE      <= 1'b0;
         DMEM_ADDR    <= '0;
         DMEM_WDATA   <= '0;
         DMEM_BE      <= '0;
         MEM_DATA_OUT <= '0;
         MEM_FAULT    <= 1'b0;
         MEM_MISALIGN <= 1'b0;
      end else begin
         MEM_FAULT    <= 1'b0;
         MEM_MISALIGN <= 1'b0;
         unique case (state)
            IDLE: begin
               if (access) begin
                  off_q  <= off;
                  size_q <= size;
                  load_q <= ~EX_MEM_WRITE;
                  if (misalign) begin
                     state        <= DONE;
                     MEM_MISALIGN <= 1'b1;
                     if (!EX_MEM_WRITE) MEM_DATA_OUT <= '0;
                  end else begin
                     state      <= REQ;
                     DMEM_REQ   <= 1'b1;
                     DMEM_WE    <= EX_MEM_WRITE;
                     DMEM_ADDR  <= {EX_ADDR[31:2], 2'b00};
                     DMEM_WDATA <= wdata;
                     DMEM_BE    <= be;
                     wait_cnt   <= '0;
                  end
               end
            end
            REQ: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               // Ack takes priority over a timeout landing in the same cycle.
               if (DMEM_ACK) begin
                  DMEM_REQ <= 1'b0;
                  DMEM_WE  <= 1'b0;
                  if (load_q) MEM_DATA_OUT <= load_data;
                  state    <= DONE;
               end else if (timeout) begin
                  DMEM_REQ  <= 1'b0;
                  DMEM_WE   <= 1'b0;
                  if (load_q) MEM_DATA_OUT <= '0;
                  MEM_FAULT <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a behavioural model of the access rules.
module tb_mem_access_stage;

   localparam int unsigned MAX_WAIT = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EX_MEM_READ, EX_MEM_WRITE;
   logic [2:0]  EX_FUNC3;
   logic [31:0] EX_ADDR, EX_STORE_DATA;
   logic        MEM_STALL, DMEM_REQ, DMEM_WE;
   logic [31:0] DMEM_ADDR, DMEM_WDATA;
   logic [3:0]  DMEM_BE;
   logic [31:0] DMEM_RDATA;
   logic        DMEM_ACK;
   logic [31:0] MEM_DATA_OUT;
   logic        MEM_FAULT, MEM_MISALIGN;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] mdl_data;

   mem_access_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST),
      .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
      .EX_FUNC3(EX_FUNC3), .EX_ADDR(EX_ADDR), .EX_STORE_DATA(EX_STORE_DATA),
      .MEM_STALL(MEM_STALL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
      .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE),
      .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
      .MEM_DATA_OUT(MEM_DATA_OUT), .MEM_FAULT(MEM_FAULT), .MEM_MISALIGN(MEM_MISALIGN)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Offset rounded down to a multiple of the access size.
   function automatic int unsigned eff_off(input int unsigned sz, input logic [31:0] addr);
      return ((addr % 4) / sz) * sz;
   endfunction

   function automatic logic [31:0] exp_wdata(input int unsigned sz, input logic [31:0] d);
      if (sz == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
      if (sz == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] exp_load(input int unsigned sz, input int unsigned o, input logic [31:0] rd);
      logic [31:0] mask;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      return (rd >> (8 * o)) & mask;
   endfunction

   function automatic logic is_misaligned(input int unsigned sz, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
      return ((addr % 4) % sz) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // Called shortly after a falling edge with the DUT idle.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int unsigned ack_dly);
      int unsigned sz, o, n;
      logic        is_load, tmo, mis;
      logic [31:0] be_exp;
      sz      = size_of(f3);
      o       = eff_off(sz, addr);
      is_load = !wr;
      mis     = is_misaligned(sz, addr);
      tmo     = ack_dly > MAX_WAIT;
      n       = tmo ? MAX_WAIT : ack_dly;
      be_exp  = ((32'd1 << sz) - 32'd1) << o;

      EX_MEM_READ = rd; EX_MEM_WRITE = wr; EX_FUNC3 = f3;
      EX_ADDR = addr; EX_STORE_DATA = sdata; DMEM_RDATA = rdata;
      #1;
      check("idle_stall", {31'b0, MEM_STALL}, 32'd1);
      check("idle_req", {31'b0, DMEM_REQ}, 32'd0);
      @(posedge CLK);

      if (mis) begin
         if (is_load) mdl_data = 32'h0;
         @(negedge CLK);
         check("mis_req", {31'b0, DMEM_REQ}, 32'd0);
         check("mis_stall", {31'b0, MEM_STALL}, 32'd0);
         check("mis_pulse", {31'b0, MEM_MISALIGN}, 32'd1);
         check("mis_data", MEM_DATA_OUT, mdl_data);
      end else begin
         for (int unsigned k = 1; k <= n; k++) begin
            @(negedge CLK);
            check("req_req", {31'b0, DMEM_REQ}, 32'd1);
            check("req_stall", {31'b0, MEM_STALL}, 32'd1);
            check("req_we", {31'b0, DMEM_WE}, {31'b0, wr});
            check("req_addr", DMEM_ADDR, {addr[31:2], 2'b00});
            check("req_be", {28'b0, DMEM_BE}, be_exp);
            check("req_wdata", DMEM_WDATA, exp_wdata(sz, sdata));
            DMEM_ACK = (k == ack_dly);
         end
         if (is_load) mdl_data = tmo ? 32'h0 : exp_load(sz, o, rdata);
         @(negedge CLK);
         DMEM_ACK = 1'($urandom % 2);
         check("done_stall", {31'b0, MEM_STALL}, 32'd0);
         check("done_req", {31'b0, DMEM_REQ}, 32'd0);
         check("done_we", {31'b0, DMEM_WE}, 32'd0);
         check("done_fault", {31'b0, MEM_FAULT}, {31'b0, tmo});
         check("done_mis", {31'b0, MEM_MISALIGN}, 32'd0);
         check("done_data", MEM_DATA_OUT, mdl_data);
      end

      @(posedge CLK);
      @(negedge CLK);
      EX_MEM_READ = 1'b0; EX_MEM_WRITE = 1'b0;
      EX_ADDR = $urandom; DMEM_ACK = 1'($urandom % 2);
      #1;
      check("tail_stall", {31'b0, MEM_STALL}, 32'd0);
      check("tail_req", {31'b0, DMEM_REQ}, 32'd0);
      check("tail_fault", {31'b0, MEM_FAULT | MEM_MISALIGN}, 32'd0);
      check("tail_data", MEM_DATA_OUT, mdl_data);
   endtask

   initial begin
      RST = 1'b1;
      EX_MEM_READ = 1'b0; EX_MEM_WRITE = 1'b0; EX_FUNC3 = 3'b000;
      EX_ADDR = '0; EX_STORE_DATA = '0; DMEM_RDATA = '0; DMEM_ACK = 1'b0;
      mdl_data = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_req", {31'b0, DMEM_REQ}, 32'd0);
      check("rst_we", {31'b0, DMEM_WE}, 32'd0);
      check("rst_addr", DMEM_ADDR, 32'd0);
      check("rst_wdata", DMEM_WDATA, 32'd0);
      check("rst_be", {28'b0, DMEM_BE}, 32'd0);
      check("rst_stall", {31'b0, MEM_STALL}, 32'd0);
      check("rst_data", MEM_DATA_OUT, 32'd0);
      check("rst_flags", {30'b0, MEM_FAULT, MEM_MISALIGN}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
      run_access(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1);
      run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234, 1);
      run_access(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1122_3344, 3);
      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 100);
      run_access(1'b1, 1'b1, 3'b001, 32'h0000_0402, 32'h1234_BEEF, 32'h7777_7777, 1);
      run_access(1'b1, 1'b0, 3'b110, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, MAX_WAIT);

      for (int i = 0; i < 60; i++) begin
         int unsigned kind;
         kind = $urandom % 3;
         run_access(kind != 1, kind != 0, 3'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(MAX_WAIT + 2, 1));
      end

      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1357_9BDF, 1);
      EX_MEM_READ = 1'b1; EX_MEM_WRITE = 1'b0; EX_FUNC3 = 3'b010; EX_ADDR = 32'h0000_0100;
      DMEM_ACK = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1; EX_MEM_READ = 1'b0;
      @(negedge CLK);
      mdl_data = 32'h0;
      check("rstreq_req", {31'b0, DMEM_REQ}, 32'd0);
      check("rstreq_stall", {31'b0, MEM_STALL}, 32'd0);
      check("rstreq_data", MEM_DATA_OUT, mdl_data);
      RST = 1'b0;
      @(negedge CLK);

      run_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hFFFF_0000, 1);
      run_access(1'b0, 1'b1, 3'b001, 32'h0000_0207, 32'hABCD_1234, 32'h0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
